// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage: owns the PC, runs a single-outstanding req/ack read on
//   instruction memory and loads the IF/ID register that feeds decode.
//   Handles decode back-pressure (stall) and branch redirect, including
//   dropping a response that was already in flight down the wrong path.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   imem_req        : read request, held until acknowledged
//   imem_addr       : request byte address, stable while imem_req=1
//   imem_ack        : read data valid this cycle (only meaningful with imem_req)
//   imem_rdata      : instruction word, valid with imem_ack
//   stall           : decode cannot accept; IF/ID holds
//   branch_taken    : redirect PC to branch_target and flush IF/ID
//   branch_target   : redirect byte address, bits [1:0] ignored
//   if_id_instr     : IF/ID instruction (0 = NOP when flushed/reset)
//   if_id_pc_plus4  : IF/ID PC+4
//   if_id_valid     : IF/ID holds a real instruction
module instruction_fetch #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [31:0]           if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n, pc_inc, tgt;
    logic [ADDR_WIDTH-1:0] addr_n, pp4_n;
    logic                  req_n, valid_n;
    logic [31:0]           hold, hold_n, instr_n;
    logic                  ack;
    logic                  tgt_lsb_unused;

    // Instruction addresses are word aligned; the low target bits carry no meaning.
    assign tgt            = {branch_target[ADDR_WIDTH-1:2], 2'b00};
    assign tgt_lsb_unused = ^branch_target[1:0];
    assign pc_inc         = pc + ADDR_WIDTH'(4);
    // An ack without a live request is not a response.
    assign ack            = imem_req & imem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            imem_req       <= 1'b0;
            imem_addr      <= RESET_PC;
            hold           <= '0;
            if_id_instr    <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            imem_req       <= req_n;
            imem_addr      <= addr_n;
            hold           <= hold_n;
            if_id_instr    <= instr_n;
            if_id_pc_plus4 <= pp4_n;
            if_id_valid    <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = imem_req;
        addr_n  = imem_addr;
        hold_n  = hold;
        instr_n = if_id_instr;
        pp4_n   = if_id_pc_plus4;
        valid_n = if_id_valid;

        // IF/ID baseline: a branch flushes to a NOP (pc_plus4 kept), a stall
        // freezes everything, otherwise a bubble unless a delivery below
        // overrides it.
        if (branch_taken) begin
            valid_n = 1'b0;
            instr_n = '0;
        end else if (!stall) begin
            valid_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                state_n = FETCH;
                req_n   = 1'b1;
                if (branch_taken) begin
                    pc_n   = tgt;
                    addr_n = tgt;
                end else begin
                    addr_n = pc;
                end
            end

            FETCH: begin
                if (branch_taken) begin
                    pc_n = tgt;
                    if (ack) begin
                        // Response is wrong-path; reissue at the target right away.
                        addr_n = tgt;
                    end else begin
                        // The request cannot be withdrawn: keep the old address
                        // up and throw its data away when it lands.
                        state_n = DISCARD;
                    end
                end else if (ack) begin
                    if (stall) begin
                        // Park the word so it is neither lost nor refetched.
                        hold_n  = imem_rdata;
                        req_n   = 1'b0;
                        state_n = HOLD;
                    end else begin
                        instr_n = imem_rdata;
                        pp4_n   = pc_inc;
                        valid_n = 1'b1;
                        pc_n    = pc_inc;
                        addr_n  = pc_inc;
                    end
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    pc_n    = tgt;
                    addr_n  = tgt;
                    req_n   = 1'b1;
                    state_n = FETCH;
                end else if (!stall) begin
                    instr_n = hold;
                    pp4_n   = pc_inc;
                    valid_n = 1'b1;
                    pc_n    = pc_inc;
                    addr_n  = pc_inc;
                    req_n   = 1'b1;
                    state_n = FETCH;
                end
            end

            DISCARD: begin
                // pc already tracks the newest redirect; imem_addr still shows
                // the stale request until its ack.
                if (branch_taken) begin
                    pc_n = tgt;
                end
                if (ack) begin
                    addr_n  = branch_taken ? tgt : pc;
                    state_n = FETCH;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] OPC = 32'h8C000000;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid;

    // second instance at the top of the address space, zero-wait memory
    logic        req_w, ack_w, valid_w, tie0;
    logic [31:0] addr_w, rdata_w, instr_w, pp4_w, tie_tgt;

    int          n_chk, n_pass, n_deliv;
    logic        mon_en;
    int          mem_mode;            // 0/2 fixed wait states, 3 random 0..3
    logic        mem_busy;
    int          mem_wl;
    logic [31:0] mem_addr;
    logic [31:0] exp_q[$];            // expected delivery addresses, program order
    logic [31:0] next_push;

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid));

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFFFFFC)) dut_w (
        .clk(clk), .rst(rst), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_rdata(rdata_w), .stall(tie0),
        .branch_taken(tie0), .branch_target(tie_tgt),
        .if_id_instr(instr_w), .if_id_pc_plus4(pp4_w),
        .if_id_valid(valid_w));

    assign tie0    = 1'b0;
    assign tie_tgt = 32'h0;
    assign ack_w   = req_w;
    assign rdata_w = addr_w | OPC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic topup();
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_push);
            next_push = next_push + 32'd4;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        topup();
    endtask

    // A branch restarts the expected program order at the aligned target.
    task automatic drive(input logic s, input logic b, input logic [31:0] t);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        if (b) begin
            exp_q.delete();
            next_push = {t[31:2], 2'b00};
            topup();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req}, 32'h0);
        chk({tag, "_addr"},  imem_addr, 32'h0);
        chk({tag, "_instr"}, if_id_instr, 32'h0);
        chk({tag, "_pp4"},   if_id_pc_plus4, 32'h0);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
    endtask

    // memory model: decides ack 2 time units after each edge
    initial begin
        imem_ack = 1'b0; imem_rdata = 32'h0; mem_busy = 1'b0; mem_wl = 0; mem_addr = 0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                mem_busy = 1'b0;
                imem_ack = 1'b0;
            end else begin
                if (imem_req && !mem_busy) begin
                    mem_busy = 1'b1;
                    mem_addr = imem_addr;
                    mem_wl   = (mem_mode == 3) ? int'($urandom_range(0, 3)) : mem_mode;
                end else if (mem_busy) begin
                    chk("addr_stable", imem_addr, mem_addr);
                    chk("req_held", {31'b0, imem_req}, 32'h1);
                end
                if (mem_busy) begin
                    if (mem_wl == 0) begin
                        imem_ack   = 1'b1;
                        imem_rdata = imem_addr | OPC;
                        mem_busy   = 1'b0;
                    end else begin
                        imem_ack = 1'b0;
                        mem_wl--;
                    end
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 32'hDEADBEEF;
                end
            end
        end
    end

    // monitor: checks IF/ID after every edge against the expected stream
    initial begin
        logic s, b, pv;
        logic [31:0] pi, pp, e;
        pi = 0; pp = 0; pv = 0;
        forever begin
            @(posedge clk);
            s = stall;
            b = branch_taken;
            #1;
            if (mon_en && !rst) begin
                if (b) begin
                    chk("flush_valid", {31'b0, if_id_valid}, 32'h0);
                    chk("flush_instr", if_id_instr, 32'h0);
                    chk("flush_pp4", if_id_pc_plus4, pp);
                end else if (s) begin
                    chk("stall_instr", if_id_instr, pi);
                    chk("stall_pp4", if_id_pc_plus4, pp);
                    chk("stall_valid", {31'b0, if_id_valid}, {31'b0, pv});
                end else if (if_id_valid) begin
                    n_deliv++;
                    chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("sb_instr", if_id_instr, e | OPC);
                        chk("sb_pp4", if_id_pc_plus4, e + 32'd4);
                    end
                end
            end
            pi = if_id_instr; pp = if_id_pc_plus4; pv = if_id_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic found;
        logic [31:0] pend, d0;
        n_chk = 0; n_pass = 0; n_deliv = 0; mon_en = 1'b0; mem_mode = 0;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        next_push = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        chk("rstw_addr", addr_w, 32'hFFFFFFFC);
        chk("rstw_req", {31'b0, req_w}, 32'h0);

        // zero-wait stream
        exp_q.delete(); next_push = 32'h0; topup();
        mon_en = 1'b1;
        rst = 1'b0;
        tick();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", {31'b0, if_id_valid}, 32'h0);
        chk("w_first_addr", addr_w, 32'hFFFFFFFC);
        tick();
        chk("zw_valid0", {31'b0, if_id_valid}, 32'h1);
        chk("w_instr0", instr_w, 32'hFFFFFFFC);
        chk("w_pp4_0", pp4_w, 32'h0);
        chk("w_addr_wrap", addr_w, 32'h0);
        tick();
        chk("zw_valid1", {31'b0, if_id_valid}, 32'h1);
        chk("w_instr1", instr_w, OPC);
        chk("w_pp4_1", pp4_w, 32'h4);
        tick();
        chk("zw_valid2", {31'b0, if_id_valid}, 32'h1);

        // two wait states: one delivery per three cycles
        mem_mode = 2;
        repeat (3) tick();
        d0 = n_deliv;
        repeat (9) tick();
        chk("wait2_rate", n_deliv - d0, 32'd3);

        // stall while a response lands
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_ack) begin found = 1'b1; break; end
        end
        chk("stall_ack_seen", {31'b0, found}, 32'h1);
        drive(1'b1, 1'b0, 32'h0);
        tick();
        chk("hold_req0", {31'b0, imem_req}, 32'h0);
        tick();
        chk("hold_req1", {31'b0, imem_req}, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("unhold_valid", {31'b0, if_id_valid}, 32'h1);
        chk("unhold_req", {31'b0, imem_req}, 32'h1);
        chk("unhold_addr", imem_addr, if_id_pc_plus4);

        // branch while a request still has two cycles to go
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req && !imem_ack && mem_busy && mem_wl == 1) begin found = 1'b1; break; end
        end
        chk("pend_seen", {31'b0, found}, 32'h1);
        pend = imem_addr;
        drive(1'b0, 1'b1, 32'h41);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("br_valid", {31'b0, if_id_valid}, 32'h0);
        chk("br_instr", if_id_instr, 32'h0);
        chk("br_req", {31'b0, imem_req}, 32'h1);
        chk("br_old_addr", imem_addr, pend);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_id_valid) begin found = 1'b1; break; end
        end
        chk("br_deliv_seen", {31'b0, found}, 32'h1);
        chk("br_tgt_pp4", if_id_pc_plus4, 32'h44);
        chk("br_tgt_instr", if_id_instr, 32'h40 | OPC);

        // branch + ack + stall together: branch wins
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_ack) begin found = 1'b1; break; end
        end
        chk("co_ack_seen", {31'b0, found}, 32'h1);
        drive(1'b1, 1'b1, 32'h100);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("co_req", {31'b0, imem_req}, 32'h1);
        chk("co_addr", imem_addr, 32'h100);
        chk("co_valid", {31'b0, if_id_valid}, 32'h0);

        // random traffic
        mem_mode = 3;
        for (int i = 0; i < 400; i++) begin
            tick();
            drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8,
                  32'($urandom_range(0, 1023)) * 32'd4 + 32'($urandom_range(0, 3)));
        end
        tick();
        drive(1'b0, 1'b0, 32'h0);

        // asynchronous reset while in DISCARD
        mem_mode = 2;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req && !imem_ack && mem_busy && mem_wl == 1) begin found = 1'b1; break; end
        end
        chk("disc_pend_seen", {31'b0, found}, 32'h1);
        pend = imem_addr;
        drive(1'b0, 1'b1, 32'h200);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("disc_addr", imem_addr, pend);
        #3;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        repeat (2) @(negedge clk);
        exp_q.delete(); next_push = 32'h0; topup();
        mon_en = 1'b1;
        rst = 1'b0;
        tick();
        chk("rerun_req", {31'b0, imem_req}, 32'h1);
        chk("rerun_addr", imem_addr, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_id_valid) begin found = 1'b1; break; end
        end
        chk("rerun_deliv_seen", {31'b0, found}, 32'h1);
        chk("rerun_pp4", if_id_pc_plus4, 32'h4);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
